multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath: PC, instruction register, register file, ALU and a single unified memory port.
- Consumes the 7-bit major opcode held in the instruction register and the branch comparator result.
- Drives all datapath write enables, mux selects and the memory request handshake. Counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter
- OPC_W, 7, major opcode width (fixed at 7 for RV32I)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = FSM may start a new fetch; sampled only in FETCH
- opcode  in  OPC_W  instr[6:0] from instruction register
- mem_ready  in  1  memory completes current request this cycle
- branch_taken  in  1  branch comparator result, valid in EXEC
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = read
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result register
- ir_we  out  1  load instruction register
- alu_out_we  out  1  latch ALU result register
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- rf_we  out  1  register file write
- wb_sel  out  2  0 = ALU result, 1 = memory data, 2 = PC+4
- pc_we  out  1  PC write
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- State, illegal and instret are registers. All other outputs are combinational from state, opcode, mem_ready and branch_taken.
- All outputs not listed as active in the current state are 0.
- Reset (rst_n=0, asynchronous, any state, including mid memory request):
  - state=FETCH, instret=0, illegal=0.
  - Every strobe and request output is forced to 0 while rst_n=0.
  - A pending memory request is abandoned.
- FETCH:
  - mem_req=run, addr_sel=0.
  - If run=1 and mem_ready=1: ir_we=1, go to DECODE. Otherwise stay.
  - run dropping while waiting withdraws mem_req.
- DECODE: one cycle.
  - Legal opcodes go to EXEC: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode goes to TRAP.
- EXEC: alu_out_we=1. Operand selects by class:
  - OP: a=0, b=0.
  - OP-IMM, LOAD, STORE, JALR: a=0, b=1.
  - LUI: a=2, b=1.
  - AUIPC: a=1, b=1.
  - BRANCH: a=0, b=0 (comparator path).
  - JAL: a=1, b=1.
- EXEC next state:
  - LOAD and STORE go to MEM.
  - BRANCH: pc_we=1, pc_sel = branch_taken ? 1 : 0; retires; go to FETCH.
  - All others go to WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE else 0. Hold until mem_ready.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE: pc_we=1, pc_sel=0; retires; go to FETCH.
- WB: rf_we=1; pc_we=1; retires; go to FETCH.
  - wb_sel: LOAD=1; JAL and JALR=2; others=0.
  - pc_sel: JAL=1; JALR=2; others=0.
- TRAP:
  - illegal set to 1 on entry. All strobes 0.
  - Stays until reset. No further fetch, regardless of run.
- Retire: instret increments by 1 in the cycle the FSM leaves for FETCH. It wraps modulo 2^CNT_WIDTH with no flag.
- Cycle counts with zero-wait memory (mem_ready=1 whenever requested):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle on mem_ready adds 1.
- Opcode is used only in DECODE/EXEC/MEM/WB. Changes on opcode while in FETCH have no effect.

Test Plan:
- Reset then run=1, mem_ready=1, opcode=0110111 (LUI) -> state sequence 0,1,2,4,0. WB has rf_we=1, wb_sel=0, pc_sel=0. EXEC has alu_a_sel=2, alu_b_sel=1. instret=1 after 4 cycles.
- LOAD with mem_ready held low 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 for 4 MEM cycles. Then WB has wb_sel=1. Total 8 cycles, instret +1.
- BRANCH 1100011: branch_taken=1 -> EXEC pc_we=1, pc_sel=1. branch_taken=0 -> pc_sel=0. Both return to FETCH after 3 cycles with no rf_we.
- JALR 1100111 -> WB rf_we=1, wb_sel=2, pc_sel=2. JAL 1101111 -> wb_sel=2, pc_sel=1.
- opcode=1111111 -> DECODE goes to TRAP (state=5), illegal=1. No mem_req for 20 cycles with run=1. rst_n pulse low -> state=0, illegal=0, instret=0.
- Assert rst_n=0 mid-MEM of a STORE -> mem_req and mem_we drop immediately (asynchronously), instret unchanged. With CNT_WIDTH=4, 16 retirements -> instret wraps 15 to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM sequencing fetch, decode, execute, memory and writeback.
module multicycle_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int OPC_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [OPC_W-1:0]     opcode,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_we,
    output logic                 alu_out_we,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] instret
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LUI    = OPC_W'(7'b0110111);
    localparam logic [OPC_W-1:0] OPC_AUIPC  = OPC_W'(7'b0010111);
    localparam logic [OPC_W-1:0] OPC_JAL    = OPC_W'(7'b1101111);
    localparam logic [OPC_W-1:0] OPC_JALR   = OPC_W'(7'b1100111);
    localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);
    localparam logic [OPC_W-1:0] OPC_LOAD   = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] OPC_STORE  = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] OPC_OPIMM  = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] OPC_OP     = OPC_W'(7'b0110011);

    state_t cur, nxt;
    logic   is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic   legal, retire, set_illegal;

    assign is_lui    = opcode == OPC_LUI;
    assign is_auipc  = opcode == OPC_AUIPC;
    assign is_jal    = opcode == OPC_JAL;
    assign is_jalr   = opcode == OPC_JALR;
    assign is_branch = opcode == OPC_BRANCH;
    assign is_load   = opcode == OPC_LOAD;
    assign is_store  = opcode == OPC_STORE;
    assign is_opimm  = opcode == OPC_OPIMM;
    assign is_op     = opcode == OPC_OP;
    assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op;

    // An instruction retires on whichever transition brings the FSM back to FETCH.
    assign retire      = (nxt == FETCH) && (cur != FETCH);
    assign set_illegal = (cur == DECODE) && !legal;
    assign state       = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (set_illegal) illegal <= 1'b1;
            if (retire) instret <= instret + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        alu_out_we = 1'b0;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        case (cur)
            FETCH: begin
                mem_req = run;
                if (run && mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: nxt = legal ? EXEC : TRAP;
            EXEC: begin
                alu_out_we = 1'b1;
                alu_a_sel  = is_lui ? 2'd2 : (is_auipc || is_jal) ? 2'd1 : 2'd0;
                alu_b_sel  = !(is_op || is_branch);
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'd1 : 2'd0;
                    nxt    = FETCH;
                end else begin
                    nxt = (is_load || is_store) ? MEM : WB;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    pc_we = is_store;
                    nxt   = is_store ? FETCH : WB;
                end
            end
            WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
                pc_sel = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                nxt    = FETCH;
            end
            TRAP:    nxt = TRAP;
            default: nxt = FETCH;
        endcase
        // Strobes must fall the instant reset asserts, not at the next edge.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_we      = 1'b0;
            alu_out_we = 1'b0;
            alu_a_sel  = 2'd0;
            alu_b_sel  = 1'b0;
            rf_we      = 1'b0;
            wb_sel     = 2'd0;
            pc_we      = 1'b0;
            pc_sel     = 2'd0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against a phase-plan model.
module tb_multicycle_ctrl;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;

    logic       clk = 0, rst_n = 0, run = 0, mem_ready = 0, branch_taken = 0;
    logic [6:0] opcode = 0;
    logic       mem_req, mem_we, addr_sel, ir_we, alu_out_we, alu_b_sel, rf_we, pc_we, illegal;
    logic [1:0] alu_a_sel, wb_sel, pc_sel;
    logic [2:0] state;
    logic [3:0] instret;

    multicycle_ctrl #(.CNT_WIDTH(4), .OPC_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .alu_out_we(alu_out_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal_op(input logic [6:0] o);
        return o inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
    endfunction

    // Model: each decoded instruction expands into a plan of remaining phases.
    int         m_state = 0;
    logic [6:0] m_op = 0;
    logic       m_ill = 0;
    logic [3:0] m_cnt = 0;
    int         plan[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_ill = 0; m_cnt = 0; plan.delete();
        end else if (m_state == 0) begin
            if (run && mem_ready) m_state = 1;
        end else if (m_state == 1) begin
            m_op = opcode;
            if (!legal_op(opcode)) begin
                m_state = 5; m_ill = 1;
            end else begin
                plan = {2};
                if (opcode == LOAD || opcode == STORE) plan.push_back(3);
                if (opcode != STORE && opcode != BRANCH) plan.push_back(4);
                m_state = plan.pop_front();
            end
        end else if (m_state != 5 && !(m_state == 3 && !mem_ready)) begin
            if (plan.size() == 0) begin
                m_state = 0; m_cnt++;
            end else begin
                m_state = plan.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        bit f, e, m, w, ends_here;
        logic [1:0] ea, ews, eps;
        f = rst_n && m_state == 0;
        e = rst_n && m_state == 2;
        m = rst_n && m_state == 3;
        w = rst_n && m_state == 4;
        ends_here = (e && m_op == BRANCH) || (m && m_op == STORE && mem_ready) || w;
        ea  = !e ? 2'd0 : m_op == LUI ? 2'd2 : (m_op == AUIPC || m_op == JAL) ? 2'd1 : 2'd0;
        ews = !w ? 2'd0 : m_op == LOAD ? 2'd1 : (m_op == JAL || m_op == JALR) ? 2'd2 : 2'd0;
        eps = (e && m_op == BRANCH) ? {1'b0, branch_taken} :
              !w ? 2'd0 : m_op == JAL ? 2'd1 : m_op == JALR ? 2'd2 : 2'd0;
        chk("state", state, m_state);
        chk("illegal", illegal, m_ill);
        chk("instret", instret, m_cnt);
        chk("mem_req", mem_req, (f && run) || m);
        chk("mem_we", mem_we, m && m_op == STORE);
        chk("addr_sel", addr_sel, m);
        chk("ir_we", ir_we, f && run && mem_ready);
        chk("alu_out_we", alu_out_we, e);
        chk("alu_a_sel", alu_a_sel, ea);
        chk("alu_b_sel", alu_b_sel, e && !(m_op == OP || m_op == BRANCH));
        chk("rf_we", rf_we, w);
        chk("wb_sel", wb_sel, ews);
        chk("pc_we", pc_we, ends_here);
        chk("pc_sel", pc_sel, ends_here ? eps : 2'd0);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    // Runs one instruction from idle FETCH and checks its length and retirement effects.
    task automatic do_instr(input string name, input logic [6:0] op, input int waits, input bit bt,
                            input int exp_n, input bit exp_rf, input int exp_wbs, input int exp_pcs);
        int n = 0, w = 0, pcs = 3, wbs = 3;
        bit rf = 0;
        logic [3:0] c0 = instret;
        opcode = op; branch_taken = bt; run = 1; mem_ready = 1;
        do begin
            tick();
            n++;
            run = 0;
            mem_ready = 1;
            if (state == 3 && w < waits) begin
                mem_ready = 0; w++;
            end
            #1;
            if (pc_we) pcs = pc_sel;
            if (rf_we) begin rf = 1; wbs = wb_sel; end
        end while (state != 0 && n < 30);
        mem_ready = 1;
        chk({name, "_cycles"}, n, exp_n);
        chk({name, "_instret"}, instret, 4'(c0 + 4'd1));
        chk({name, "_rf_we"}, rf, exp_rf);
        if (exp_rf) chk({name, "_wb_sel"}, wbs, exp_wbs);
        chk({name, "_pc_sel"}, pcs, exp_pcs);
    endtask

    initial begin
        int lui_seq[4] = '{1, 2, 4, 0};
        logic [6:0] cur_op;
        run = 1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_instret", instret, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mem_req", mem_req, 0);
        run = 0;
        tick();
        rst_n = 1;
        opcode = LUI; run = 1; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("lui_seq", state, lui_seq[i]);
            if (i == 1) begin chk("lui_a_sel", alu_a_sel, 2); chk("lui_b_sel", alu_b_sel, 1); end
            if (i == 2) begin chk("lui_rf_we", rf_we, 1); chk("lui_wb_sel", wb_sel, 0); chk("lui_pc_sel", pc_sel, 0); end
        end
        run = 0;
        chk("lui_instret", instret, 1);
        tick();
        do_instr("load", LOAD, 3, 0, 8, 1, 1, 0);
        do_instr("br_t", BRANCH, 0, 1, 3, 0, 0, 1);
        do_instr("br_nt", BRANCH, 0, 0, 3, 0, 0, 0);
        do_instr("jalr", JALR, 0, 0, 4, 1, 2, 2);
        do_instr("jal", JAL, 0, 0, 4, 1, 2, 1);
        do_instr("store", STORE, 0, 0, 4, 0, 0, 0);
        do_instr("auipc", AUIPC, 0, 0, 4, 1, 0, 0);
        opcode = 7'h7F; run = 1; mem_ready = 1;
        tick(); tick();
        #1;
        chk("trap_state", state, 5);
        chk("trap_illegal", illegal, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            chk("trap_mem_req", mem_req, 0);
        end
        #1 rst_n = 0;
        #1;
        chk("trap_rst_state", state, 0);
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_instret", instret, 0);
        tick();
        rst_n = 1;
        run = 0;
        opcode = STORE; run = 1; mem_ready = 1;
        tick();
        run = 0;
        tick();
        mem_ready = 0;
        tick();
        #1;
        chk("st_mem_req", mem_req, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_instret_pre", instret, 0);
        #1 rst_n = 0;
        #1;
        chk("st_rst_mem_req", mem_req, 0);
        chk("st_rst_mem_we", mem_we, 0);
        chk("st_rst_state", state, 0);
        chk("st_rst_instret", instret, 0);
        tick();
        rst_n = 1;
        mem_ready = 1;
        for (int i = 0; i < 16; i++) begin
            do_instr("wrap", LUI, 0, 0, 4, 1, 0, 0);
            if (i == 14) chk("wrap_15", instret, 15);
        end
        chk("wrap_0", instret, 0);
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            cur_op = LUI;
            for (int c = 0; c < 300; c++) begin
                run = $urandom_range(0, 3) != 0;
                mem_ready = $urandom_range(0, 9) < 6;
                branch_taken = $urandom_range(0, 1) == 1;
                if (m_state == 0) begin
                    opcode = 7'($urandom);
                    case ($urandom_range(0, 33))
                        0, 1, 2: cur_op = LUI;      3, 4, 5: cur_op = AUIPC;
                        6, 7, 8: cur_op = JAL;      9, 10, 11: cur_op = JALR;
                        12, 13, 14, 15: cur_op = BRANCH;
                        16, 17, 18, 19: cur_op = LOAD;
                        20, 21, 22, 23: cur_op = STORE;
                        24, 25, 26, 27: cur_op = OPIMM;
                        33: cur_op = 7'($urandom);
                        default: cur_op = OP;
                    endcase
                end else begin
                    opcode = cur_op;
                end
                if ($urandom_range(0, 199) == 0) begin
                    #1 rst_n = 0;
                    tick();
                    rst_n = 1;
                end else begin
                    tick();
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
